// File: rtl/fll_cfg_ctrl.sv
// fll_cfg_ctrl: boots the FLL over its 4-phase config port, waits for a stable
// lock before moving the system clock onto the FLL, and afterwards serialises
// host register accesses onto the same port.
module fll_cfg_ctrl #(
   parameter logic [31:0] CFG1_VAL     = 32'h0000_0000,
   parameter logic [31:0] CFG2_VAL     = 32'h0000_0000,
   parameter int          SYNC_STAGES  = 2,
   parameter int          LOCK_STABLE  = 16,
   parameter int          LOCK_TIMEOUT = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        host_req_i,
   input  logic        host_wrn_i,
   input  logic [1:0]  host_add_i,
   input  logic [31:0] host_data_i,
   output logic        host_ack_o,
   output logic [31:0] host_r_data_o,
   output logic        fll_req_o,
   output logic        fll_wrn_o,
   output logic [1:0]  fll_add_o,
   output logic [31:0] fll_data_o,
   input  logic        fll_ack_i,
   input  logic [31:0] fll_r_data_i,
   input  logic        fll_lock_i,
   output logic        fll_pwr_o,
   output logic        clk_sel_o,
   output logic        cfg_done_o,
   output logic        cfg_err_o
);

   localparam int STW = $clog2(LOCK_STABLE + 1);
   localparam int TOW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WR1, WR2, WAIT_LOCK, LOCKED, ERR, XFER, ACKLOW
   } state_t;

   state_t                 state_reg, state_next;
   state_t                 ret_reg, ret_next;
   logic [SYNC_STAGES-1:0] ack_sync_reg;
   logic [SYNC_STAGES-1:0] lock_sync_reg;
   logic [STW-1:0]         stable_reg, stable_next;
   logic [TOW-1:0]         tmo_reg, tmo_next;
   logic                   req_reg, req_next;
   logic                   wrn_reg, wrn_next;
   logic [1:0]             add_reg, add_next;
   logic [31:0]            data_reg, data_next;
   logic                   pwr_reg, pwr_next;
   logic                   clk_sel_reg, clk_sel_next;
   logic                   done_reg, done_next;
   logic                   err_reg, err_next;
   logic                   host_ack_reg, host_ack_next;
   logic [31:0]            r_data_reg, r_data_next;
   logic                   ack_s;
   logic                   lock_s;

   assign ack_s  = ack_sync_reg[SYNC_STAGES-1];
   assign lock_s = lock_sync_reg[SYNC_STAGES-1];

   // Synchronisers; lock from an unpowered FLL is meaningless, so that chain
   // is held clear until the FLL is powered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_sync_reg  <= '0;
         lock_sync_reg <= '0;
      end else begin
         ack_sync_reg  <= {ack_sync_reg[SYNC_STAGES-2:0], fll_ack_i};
         lock_sync_reg <= pwr_reg ? {lock_sync_reg[SYNC_STAGES-2:0], fll_lock_i} : '0;
      end
   end

   // State, counters and every output register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         ret_reg      <= IDLE;
         stable_reg   <= '0;
         tmo_reg      <= '0;
         req_reg      <= 1'b0;
         wrn_reg      <= 1'b0;
         add_reg      <= 2'd0;
         data_reg     <= 32'd0;
         pwr_reg      <= 1'b0;
         clk_sel_reg  <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         host_ack_reg <= 1'b0;
         r_data_reg   <= 32'd0;
      end else begin
         state_reg    <= state_next;
         ret_reg      <= ret_next;
         stable_reg   <= stable_next;
         tmo_reg      <= tmo_next;
         req_reg      <= req_next;
         wrn_reg      <= wrn_next;
         add_reg      <= add_next;
         data_reg     <= data_next;
         pwr_reg      <= pwr_next;
         clk_sel_reg  <= clk_sel_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         host_ack_reg <= host_ack_next;
         r_data_reg   <= r_data_next;
      end
   end

   // Next-state and next-output logic; everything holds unless changed here.
   always_comb begin
      state_next    = state_reg;
      ret_next      = ret_reg;
      stable_next   = stable_reg;
      tmo_next      = tmo_reg;
      req_next      = req_reg;
      wrn_next      = wrn_reg;
      add_next      = add_reg;
      data_next     = data_reg;
      pwr_next      = pwr_reg;
      clk_sel_next  = clk_sel_reg;
      err_next      = err_reg;
      host_ack_next = 1'b0;
      r_data_next   = r_data_reg;
      case (state_reg)
         IDLE: begin
            if (en_i) begin
               state_next = WR1;
               req_next   = 1'b1;
               wrn_next   = 1'b0;
               add_next   = 2'd1;
               data_next  = CFG1_VAL;
            end
         end
         WR1, WR2: begin
            if (ack_s) begin
               req_next   = 1'b0;
               ret_next   = (state_reg == WR1) ? WR2 : WAIT_LOCK;
               state_next = ACKLOW;
            end
         end
         ACKLOW: begin
            // The access is complete only once the ack has been seen low.
            if (!ack_s) begin
               state_next = ret_reg;
               if (ret_reg == WR2) begin
                  req_next  = 1'b1;
                  wrn_next  = 1'b0;
                  add_next  = 2'd2;
                  data_next = CFG2_VAL;
               end else if (ret_reg == WAIT_LOCK) begin
                  pwr_next    = 1'b1;
                  stable_next = '0;
                  tmo_next    = '0;
               end
            end
         end
         WAIT_LOCK: begin
            if (!lock_s)
               stable_next = '0;
            else if (stable_reg != STW'(LOCK_STABLE))
               stable_next = stable_reg + 1'b1;
            if (tmo_reg != TOW'(LOCK_TIMEOUT))
               tmo_next = tmo_reg + 1'b1;
            if (stable_reg == STW'(LOCK_STABLE)) begin
               state_next   = LOCKED;
               clk_sel_next = 1'b1;
            end else if (tmo_reg == TOW'(LOCK_TIMEOUT)) begin
               state_next = ERR;
               err_next   = 1'b1;
            end
         end
         LOCKED, ERR: begin
            // Lock loss is checked first so it wins over a simultaneous host request.
            if (state_reg == LOCKED && !lock_s) begin
               state_next   = WAIT_LOCK;
               clk_sel_next = 1'b0;
               stable_next  = '0;
               tmo_next     = '0;
            end else if (host_req_i) begin
               state_next = XFER;
               ret_next   = state_reg;
               req_next   = 1'b1;
               wrn_next   = host_wrn_i;
               add_next   = host_add_i;
               data_next  = host_data_i;
            end
         end
         XFER: begin
            if (ack_s) begin
               req_next      = 1'b0;
               host_ack_next = 1'b1;
               if (wrn_reg)
                  r_data_next = fll_r_data_i;
               state_next = ACKLOW;
            end
         end
         default: state_next = IDLE;
      endcase
      done_next = (state_next == LOCKED);
   end

   assign host_ack_o    = host_ack_reg;
   assign host_r_data_o = r_data_reg;
   assign fll_req_o     = req_reg;
   assign fll_wrn_o     = wrn_reg;
   assign fll_add_o     = add_reg;
   assign fll_data_o    = data_reg;
   assign fll_pwr_o     = pwr_reg;
   assign clk_sel_o     = clk_sel_reg;
   assign cfg_done_o    = done_reg;
   assign cfg_err_o     = err_reg;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// tb_fll_cfg_ctrl: scoreboard bench for fll_cfg_ctrl with a small FLL port
// stub (combinational or 4-cycle-delayed ack, 4-word register file).
module tb_fll_cfg_ctrl;

   localparam logic [31:0] CFG1 = 32'h1234_5678;
   localparam logic [31:0] CFG2 = 32'h9ABC_DEF0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        host_req = 1'b0;
   logic        host_wrn = 1'b0;
   logic [1:0]  host_add = 2'd0;
   logic [31:0] host_data = 32'd0;
   logic        host_ack;
   logic [31:0] host_r_data;
   logic        fll_req, fll_wrn, fll_ack, fll_pwr, clk_sel, cfg_done, cfg_err;
   logic [1:0]  fll_add;
   logic [31:0] fll_data, fll_r_data;
   logic        lock = 1'b1;
   logic        slow = 1'b0;
   logic [3:0]  ack_hist = 4'd0;
   logic [31:0] stub_mem [4] = '{32'h0BAD_F00D, 32'd0, 32'd0, 32'hC0FF_EE03};

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int base = 0;
   int ack_at;

   typedef struct {
      logic        wrn;
      logic [1:0]  add;
      logic [31:0] data;
      int          at;
   } port_t;

   port_t       port_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] last_rd = 32'd0;

   assign fll_ack    = slow ? ack_hist[3] : fll_req;
   assign fll_r_data = stub_mem[fll_add];

   fll_cfg_ctrl #(
      .CFG1_VAL(CFG1), .CFG2_VAL(CFG2), .SYNC_STAGES(2),
      .LOCK_STABLE(16), .LOCK_TIMEOUT(64)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en),
      .host_req_i(host_req), .host_wrn_i(host_wrn), .host_add_i(host_add),
      .host_data_i(host_data), .host_ack_o(host_ack), .host_r_data_o(host_r_data),
      .fll_req_o(fll_req), .fll_wrn_o(fll_wrn), .fll_add_o(fll_add),
      .fll_data_o(fll_data), .fll_ack_i(fll_ack), .fll_r_data_i(fll_r_data),
      .fll_lock_i(lock), .fll_pwr_o(fll_pwr), .clk_sel_o(clk_sel),
      .cfg_done_o(cfg_done), .cfg_err_o(cfg_err)
   );

   always #5 clk = ~clk;

   // Cycle counter and the delayed-ack shift register of the port stub.
   initial forever @(posedge clk) begin
      cyc      <= cyc + 1;
      ack_hist <= {ack_hist[2:0], fll_req};
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc - base);
      end
   endtask

   task automatic goto(input int c);
      while (cyc - base < c) @(negedge clk);
   endtask

   task automatic push_boot();
      port_q.push_back('{1'b0, 2'd1, CFG1, 1});
      port_q.push_back('{1'b0, 2'd2, CFG2, 7});
   endtask

   task automatic host_access(input logic wrn, input logic [1:0] add, input logic [31:0] data,
                              input logic [31:0] exp_rd, output int at);
      int n;
      if (wrn) last_rd = exp_rd;
      rd_q.push_back(last_rd);
      port_q.push_back('{wrn, add, data, -1});
      host_wrn  = wrn;
      host_add  = add;
      host_data = data;
      host_req  = 1'b1;
      n = 0;
      while (!host_ack && n < 200) begin
         @(negedge clk);
         n++;
      end
      at = cyc - base;
      if (!host_ack) check_eq("host_ack_timeout", 64'd0, 64'd1);
      host_req = 1'b0;
   endtask

   // Monitor: stub register writes, port-transaction and host-ack scoreboards.
   initial begin
      logic  prev_req;
      logic  prev_ack;
      port_t e;
      prev_req = 1'b0;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (fll_req && fll_ack && !fll_wrn) stub_mem[fll_add] = fll_data;
         if (fll_req && !prev_req) begin
            $display("port  : cycle %0d wrn=%0b add=%0d data=%08h", cyc - base, fll_wrn, fll_add, fll_data);
            if (port_q.size() == 0) check_eq("port_unexpected", 64'd1, 64'd0);
            else begin
               e = port_q.pop_front();
               check_eq("port_fields", {fll_wrn, fll_add, fll_data}, {e.wrn, e.add, e.data});
               if (e.at >= 0) check_eq("port_start_cycle", 64'(cyc - base), 64'(e.at));
            end
         end
         if (host_ack) begin
            $display("host  : cycle %0d ack r_data=%08h", cyc - base, host_r_data);
            check_eq("host_ack_width", prev_ack, 0);
            if (rd_q.size() == 0) check_eq("host_ack_unexpected", 64'd1, 64'd0);
            else check_eq("host_r_data", host_r_data, rd_q.pop_front());
         end
         prev_req = fll_req;
         prev_ack = host_ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", {host_ack, fll_req, fll_wrn, fll_add, fll_pwr, clk_sel, cfg_done, cfg_err}, 0);
      check_eq("rst_r_data", host_r_data, 0);
      check_eq("rst_w_data", fll_data, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("idle_no_req", fll_req, 0);

      // Boot with lock tied high and a combinational ack
      base = cyc;
      en   = 1'b1;
      push_boot();
      goto(12); check_eq("boot_pwr_c12", fll_pwr, 0);
      goto(13); check_eq("boot_pwr_c13", fll_pwr, 1);
      goto(31); check_eq("boot_sel_c31", {clk_sel, cfg_done}, 2'b00);
      goto(32); check_eq("boot_sel_c32", {clk_sel, cfg_done, cfg_err}, 3'b110);
      en = 1'b0;
      goto(40); check_eq("en_drop_no_effect", {clk_sel, cfg_done}, 2'b11);

      // Lock drops for 5 cycles
      base = cyc;
      lock = 1'b0;
      goto(2);  check_eq("drop_sel_c2", clk_sel, 1);
      goto(3);  check_eq("drop_sel_c3", {clk_sel, cfg_done}, 2'b00);
      goto(5);  lock = 1'b1;
      goto(23); check_eq("relock_sel_c23", clk_sel, 0);
      goto(24); check_eq("relock_sel_c24", {clk_sel, cfg_done, cfg_err}, 3'b110);

      // Host read, write, read-back through a slow (4-cycle) ack
      goto(30);
      slow = 1'b1;
      host_access(1'b1, 2'd1, 32'hDEAD_BEEF, CFG1, ack_at);
      repeat (20) @(negedge clk);
      host_access(1'b0, 2'd0, 32'h5555_AAAA, 32'd0, ack_at);
      repeat (20) @(negedge clk);
      host_access(1'b1, 2'd0, 32'h0123_4567, 32'h5555_AAAA, ack_at);
      repeat (20) @(negedge clk);
      check_eq("xfer_sel_held", {clk_sel, cfg_done}, 2'b11);
      slow = 1'b0;
      repeat (4) @(negedge clk);

      // Lock loss and host request seen in the same cycle
      base = cyc;
      lock = 1'b0;
      fork
         begin
            goto(3); check_eq("tie_sel_c3", clk_sel, 0);
            goto(5); lock = 1'b1;
         end
         begin
            goto(2);
            host_access(1'b1, 2'd2, 32'd0, CFG2, ack_at);
         end
      join
      check_eq("tie_ack_cycle", 64'(ack_at), 64'd28);

      // Reset in the middle of WR2, then boot with no lock (timeout)
      @(negedge clk);
      rst  = 1'b1;
      lock = 1'b0;
      en   = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      base = cyc;
      push_boot();
      goto(8);
      check_eq("wr2_active", {fll_req, fll_add}, 3'b110);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_ctrl", {host_ack, fll_req, fll_wrn, fll_add, fll_pwr, clk_sel, cfg_done, cfg_err}, 0);
      check_eq("mid_rst_w_data", fll_data, 0);
      @(negedge clk);
      rst  = 1'b0;
      base = cyc;
      push_boot();
      goto(13); check_eq("tmo_pwr_c13", fll_pwr, 1);
      goto(73); check_eq("tmo_err_c73", cfg_err, 0);
      goto(80); check_eq("tmo_err_c80", {cfg_err, clk_sel, fll_pwr, cfg_done}, 4'b1010);
      host_access(1'b1, 2'd3, 32'd0, 32'hC0FF_EE03, ack_at);
      repeat (10) @(negedge clk);
      check_eq("err_sticky", {cfg_err, clk_sel}, 2'b10);

      check_eq("port_queue_empty", port_q.size(), 0);
      check_eq("rd_queue_empty", rd_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
